// File: rtl/hdr_pkg.sv
// Shared types and defaults for the HDR line pairer: FSM states, size defaults, pixel-pair record.
// Pure declarations; no logic, no latency, no flow control.
package hdr_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_WIDTH_DEF  = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        PAIR  = 2'd2
    } state_t;

    // e0 = short exposure (stored line), e1 = long exposure (live line)
    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] e0;
        logic [DATA_WIDTH_DEF-1:0] e1;
    } pix_pair_t;

endpackage

// File: rtl/hdr_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Read latency 1 cycle; read data holds when rd_en is low; no backpressure.
module hdr_line_ram #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 2048,
    localparam int RAW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [RAW-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [RAW-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the pair output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/hdr_line_pairer.sv
// Pairs each buffered even (short) line with the following odd (long) line; HDR_PAIR_SWAP_EN adds swap_i.
// Latency 1 cycle from odd-line pixel to pair; no backpressure, valid_o gaps follow valid_i.
module hdr_line_pairer
    import hdr_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int MAX_WIDTH  = MAX_WIDTH_DEF,
    localparam int AW         = $clog2(MAX_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef HDR_PAIR_SWAP_EN
    input  logic                  swap_i,
`endif
    input  logic                  valid_i,
    input  logic                  sof_i,
    input  logic                  eol_i,
    input  logic [DATA_WIDTH-1:0] pix_i,
    output logic                  valid_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic [DATA_WIDTH-1:0] data_o0,
    output logic [DATA_WIDTH-1:0] data_o1,
    output logic                  err_o
);

    localparam int            RAW  = AW - 1;
    localparam logic [AW-1:0] MAXW = AW'(MAX_WIDTH);

    state_t          state, state_n;
    logic [AW-1:0]   col, col_n;
    logic [AW-1:0]   stored_len, len_n;
    logic            err_n;
    logic            sof_pend, sof_pend_n;
    logic            wr_en, rd_en, pair, dup;
    logic [RAW-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] rd_data, live_q, stored_pix;
    logic            dup_q;
    logic            swap_q;

    always_comb begin
        state_n    = state;
        col_n      = col;
        len_n      = stored_len;
        err_n      = err_o;
        sof_pend_n = sof_pend;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        pair       = 1'b0;
        dup        = 1'b0;
        wr_addr    = col[RAW-1:0];
        if (valid_i) begin
            if (sof_i) begin
                // Restart wins over everything, including a simultaneous eol.
                state_n    = STORE;
                col_n      = AW'(1);
                wr_en      = 1'b1;
                wr_addr    = '0;
                err_n      = 1'b0;
                sof_pend_n = 1'b1;
            end else begin
                case (state)
                    STORE: begin
                        if (col < MAXW) begin
                            wr_en = 1'b1;
                            col_n = col + AW'(1);
                        end else begin
                            err_n = 1'b1;
                        end
                        if (eol_i) begin
                            len_n   = (col < MAXW) ? col + AW'(1) : MAXW;
                            col_n   = '0;
                            state_n = PAIR;
                        end
                    end
                    PAIR: begin
                        pair       = 1'b1;
                        sof_pend_n = 1'b0;
                        if (col < stored_len) begin
                            rd_en = 1'b1;
                        end else begin
                            dup   = 1'b1;
                            err_n = 1'b1;
                        end
                        if (col < MAXW) begin
                            col_n = col + AW'(1);
                        end
                        if (eol_i) begin
                            if (col + AW'(1) < stored_len) begin
                                err_n = 1'b1;
                            end
                            col_n   = '0;
                            state_n = STORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            stored_len <= '0;
            err_o      <= 1'b0;
            sof_pend   <= 1'b0;
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            eol_o      <= 1'b0;
            live_q     <= '0;
            dup_q      <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            stored_len <= len_n;
            err_o      <= err_n;
            sof_pend   <= sof_pend_n;
            valid_o    <= pair;
            sof_o      <= pair & sof_pend;
            eol_o      <= pair & eol_i;
            if (pair) begin
                live_q <= pix_i;
                dup_q  <= dup;
            end
        end
    end

`ifdef HDR_PAIR_SWAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            swap_q <= 1'b0;
        end else if (valid_i && sof_i) begin
            swap_q <= swap_i;
        end
    end
`else
    assign swap_q = 1'b0;
`endif

    hdr_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (pix_i),
        .rd_en   (rd_en),
        .rd_addr (col[RAW-1:0]),
        .rd_data (rd_data)
    );

    // Beyond the stored length the live pixel stands in for the missing short one.
    assign stored_pix = dup_q ? live_q : rd_data;
    assign data_o0    = swap_q ? live_q : stored_pix;
    assign data_o1    = swap_q ? stored_pix : live_q;

endmodule

// File: tb/tb_hdr_line_pairer.sv
// Randomised and directed bench for hdr_line_pairer against a queue-based line model.
module tb_hdr_line_pairer;
    import hdr_pkg::*;

    localparam int DW   = 8;
    localparam int MAXW = 16;
`ifdef HDR_PAIR_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_i = 1'b0;
    logic          sof_i = 1'b0;
    logic          eol_i = 1'b0;
    logic          swap_i = 1'b0;
    logic [DW-1:0] pix_i = '0;
    logic          valid_o, sof_o, eol_o, err_o;
    logic [DW-1:0] data_o0, data_o1;

    always #5 clk = ~clk;

    hdr_line_pairer #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (MAXW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef HDR_PAIR_SWAP_EN
        .swap_i  (swap_i),
`endif
        .valid_i (valid_i),
        .sof_i   (sof_i),
        .eol_i   (eol_i),
        .pix_i   (pix_i),
        .valid_o (valid_o),
        .sof_o   (sof_o),
        .eol_o   (eol_o),
        .data_o0 (data_o0),
        .data_o1 (data_o1),
        .err_o   (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 = waiting for sof, 1 = collecting short line, 2 = walking long line
    int            mode = 0;
    logic [DW-1:0] line0[$];
    int            k = 0;
    bit            first_pair = 0, m_err = 0, m_swap = 0;

    bit            chk_en = 0;
    bit            exp_rst = 0, exp_valid = 0, exp_sof = 0, exp_eol = 0, exp_err = 0;
    logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;

    pix_pair_t     seen[$];
    int            sof_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function void model_step(input bit rst, input bit v, input bit s, input bit e,
                             input logic [DW-1:0] p, input bit sw);
        logic [DW-1:0] st;
        exp_rst   = rst;
        exp_valid = 0;
        exp_sof   = 0;
        exp_eol   = 0;
        if (rst) begin
            mode = 0; line0.delete(); k = 0;
            first_pair = 0; m_err = 0; m_swap = 0;
            exp_d0 = '0; exp_d1 = '0;
        end else if (v) begin
            if (s) begin
                mode = 1; line0.delete(); line0.push_back(p);
                m_err = 0; first_pair = 1; m_swap = SWAP_EN && sw;
            end else if (mode == 1) begin
                if (line0.size() < MAXW) line0.push_back(p);
                else m_err = 1;
                if (e) begin
                    mode = 2; k = 0;
                end
            end else if (mode == 2) begin
                st = (k < line0.size()) ? line0[k] : p;
                if (k >= line0.size()) m_err = 1;
                if (e && (k + 1 < line0.size())) m_err = 1;
                exp_d0    = m_swap ? p : st;
                exp_d1    = m_swap ? st : p;
                exp_valid = 1;
                exp_sof   = first_pair;
                first_pair = 0;
                exp_eol   = e;
                k++;
                if (e) begin
                    mode = 1; line0.delete();
                end
            end
        end
        exp_err = m_err;
    endfunction

    // Inputs change at posedge+2; outputs of the previous inputs are checked at posedge+1.
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("valid_o", valid_o, exp_valid);
            check("sof_o", sof_o, exp_sof);
            check("eol_o", eol_o, exp_eol);
            check("err_o", err_o, exp_err);
            if (exp_valid || exp_rst) begin
                check("data_o0", data_o0, exp_d0);
                check("data_o1", data_o1, exp_d1);
            end
            if (valid_o) begin
                seen.push_back('{e0: data_o0, e1: data_o1});
                if (sof_o) sof_cnt++;
            end
        end
    end

    task automatic drive(input bit rst, input bit v, input bit s, input bit e,
                         input logic [DW-1:0] p, input bit sw);
        @(posedge clk);
        #2;
        reset = rst; valid_i = v; sof_i = s; eol_i = e; pix_i = p; swap_i = sw;
        model_step(rst, v, s, e, p, sw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), 0);
    endtask

    task automatic send_line(input int n, input int base, input bit sof, input bit gap, input bit sw);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, sof && (i == 0), i == n - 1, DW'(base + i), sw);
            if (gap) idle(1);
        end
    endtask

    task automatic clear_log();
        seen.delete();
        sof_cnt = 0;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        drive(1, 1, 1, 0, 8'h55, 0);
        idle(2);

        // basic pairing
        clear_log();
        send_line(4, 10, 1, 0, 0);
        send_line(4, 20, 0, 0, 0);
        idle(2);
        check("basic_count", seen.size(), 4);
        check("basic_p0", seen[0], {8'd10, 8'd20});
        check("basic_p3", seen[3], {8'd13, 8'd23});
        check("basic_sofcnt", sof_cnt, 1);
        check("basic_err", err_o, 0);

        // multi-line gapped frame
        clear_log();
        for (int l = 0; l < 6; l++) send_line(8, 16 * l, l == 0, 1, 0);
        idle(2);
        check("multi_count", seen.size(), 24);
        check("multi_sofcnt", sof_cnt, 1);
        check("multi_p8", seen[8], {8'd32, 8'd48});

        // long odd line
        clear_log();
        send_line(3, 1, 1, 0, 0);
        send_line(5, 4, 0, 0, 0);
        idle(2);
        check("long_p2", seen[2], {8'd3, 8'd6});
        check("long_p3", seen[3], {8'd7, 8'd7});
        check("long_p4", seen[4], {8'd8, 8'd8});
        check("long_err", err_o, 1);

        // short odd line, then recovery
        clear_log();
        send_line(4, 30, 1, 0, 0);
        send_line(2, 40, 0, 0, 0);
        idle(2);
        check("short_count", seen.size(), 2);
        check("short_err", err_o, 1);
        clear_log();
        send_line(4, 50, 1, 0, 0);
        send_line(4, 60, 0, 0, 0);
        idle(2);
        check("recover_err", err_o, 0);
        check("recover_p3", seen[3], {8'd53, 8'd63});

        // reset in the middle of an odd line
        clear_log();
        send_line(4, 70, 1, 0, 0);
        drive(0, 1, 0, 0, 8'd80, 0);
        drive(1, 1, 0, 0, 8'd81, 0);
        drive(0, 1, 0, 0, 8'd82, 0);
        drive(0, 1, 0, 1, 8'd83, 0);
        send_line(3, 90, 0, 0, 0);
        send_line(3, 95, 0, 0, 0);
        idle(2);
        check("rst_count", seen.size(), 1);
        check("rst_valid", valid_o, 0);

        // overflow of the stored line
        clear_log();
        send_line(MAXW + 2, 100, 1, 0, 0);
        send_line(MAXW + 2, 150, 0, 0, 0);
        idle(2);
        check("ovf_err", err_o, 1);
        check("ovf_p15", seen[15], {8'd115, 8'd165});
        check("ovf_p16", seen[16], {8'd166, 8'd166});

`ifdef HDR_PAIR_SWAP_EN
        clear_log();
        send_line(2, 5, 1, 0, 1);
        send_line(2, 7, 0, 0, 0);
        idle(2);
        check("swap_p0", seen[0], {8'd7, 8'd5});
        check("swap_p1", seen[1], {8'd8, 8'd6});
`endif

        // randomised traffic
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) drive(1, 1'($urandom_range(0, 1)), 0, 0, DW'($urandom), 0);
            else send_line($urandom_range(1, MAXW + 4), $urandom_range(0, 255), r < 4,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
